// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and the
// mask scan helper used to pick the next channel to release.
package reset_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HOLD = 2'd1,
    REL  = 2'd2,
    RUN  = 2'd3
  } state_t;

  // Result of a mask scan: index of the found bit plus a valid flag.
  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } nsb_t;

  // Lowest set bit of mask at position >= from (up to 16 channels).
  function automatic nsb_t next_set_bit(input logic [15:0] mask, input logic [4:0] from);
    nsb_t res;
    res.valid = 1'b0;
    res.idx   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= from)) begin
        res.valid = 1'b1;
        res.idx   = 4'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Deassertion synchroniser: STAGES-deep flop chain, cleared asynchronously
// by aresetn and released synchronously to clk.
module reset_seq_sync #(
  parameter int STAGES = 4
) (
  input  logic clk,
  input  logic aresetn,
  output logic sync_rel
);

  logic [STAGES-1:0] chain_r;

  // Shift a constant one through the chain once reset is released.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      chain_r <= {STAGES{1'b0}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], 1'b1};
    end
  end

  assign sync_rel = chain_r[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer top. Synchronises board reset release, then releases NCH
// channels in ascending order after a hold time with a gap between channels.
// Software can re-run the sequence on a masked subset of channels.
// Optional feature macro: RESET_SEQ_SWCNT_EN (software sequence counter).
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int FANOUT   = 32,
  parameter int SRWIDTH  = 4,
  parameter int CNTWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [CNTWIDTH-1:0]   hold_cycles,
  input  logic [CNTWIDTH-1:0]   gap_cycles,
  input  logic                  swreset_req,
  input  logic [NCH-1:0]        chmask,
  output logic [NCH*FANOUT-1:0] resetn,
  output logic                  busy,
  output logic                  req_drop,
  output logic [15:0]           swreset_cnt
);

  localparam logic [CNTWIDTH-1:0] CNT_ZERO = {CNTWIDTH{1'b0}};
  localparam logic [CNTWIDTH-1:0] CNT_ONE  = {{(CNTWIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNTWIDTH-1:0] CNT_MAX  = {CNTWIDTH{1'b1}};

  logic                  sync_rel_s;
  state_t                state_r, state_s;
  logic [CNTWIDTH-1:0]   cnt_r, cnt_s;
  logic [CNTWIDTH-1:0]   hold_r, hold_s;
  logic [CNTWIDTH-1:0]   gap_r, gap_s;
  logic [CNTWIDTH-1:0]   hmax_s;
  logic [3:0]            k_r, k_s;
  logic [NCH-1:0]        mask_r, mask_s;
  logic [15:0]           mask16_s;
  logic [NCH-1:0]        ch_cur_s, ch_s;
  logic                  busy_r, busy_s;
  logic                  drop_r, drop_s;
  logic [NCH*FANOUT-1:0] resetn_r;
  nsb_t                  nb_s, first_s;

  reset_seq_sync #(.STAGES(SRWIDTH)) u_sync (
    .clk      (clk),
    .aresetn  (aresetn),
    .sync_rel (sync_rel_s)
  );

  // Current per-channel release state, taken from the first replica.
  always_comb begin
    ch_cur_s = {NCH{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      ch_cur_s[k] = resetn_r[k*FANOUT];
    end
  end

  // Next-state and datapath decode for the sequencer FSM.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    hold_s   = hold_r;
    gap_s    = gap_r;
    k_s      = k_r;
    mask_s   = mask_r;
    ch_s     = ch_cur_s;
    busy_s   = busy_r;
    drop_s   = 1'b0;
    mask16_s = 16'h0000;
    mask16_s[NCH-1:0] = mask_r;
    hmax_s   = (hold_r == CNT_ZERO) ? CNT_ONE : hold_r;
    nb_s     = next_set_bit(mask16_s, 5'(k_r) + 5'd1);
    first_s  = next_set_bit(mask16_s, 5'd0);

    case (state_r)
      SYNC: begin
        drop_s = swreset_req;
        busy_s = 1'b1;
        if (sync_rel_s) begin
          hold_s  = hold_cycles;
          gap_s   = gap_cycles;
          mask_s  = {NCH{1'b1}};
          cnt_s   = CNT_ZERO;
          state_s = HOLD;
        end else begin
          state_s = SYNC;
        end
      end

      HOLD: begin
        drop_s = swreset_req;
        if (cnt_r == hmax_s - CNT_ONE) begin
          cnt_s   = CNT_ZERO;
          k_s     = first_s.idx;
          state_s = REL;
        end else begin
          cnt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
        end
      end

      REL: begin
        drop_s = swreset_req;
        // Release happens in the first cycle of each channel slot.
        if (cnt_r == CNT_ZERO) begin
          for (int i = 0; i < NCH; i++) begin
            if (k_r == 4'(i)) begin
              ch_s[i] = 1'b1;
            end else begin
              ch_s[i] = ch_s[i];
            end
          end
          // Last channel: no trailing gap, busy drops with the release.
          if (!nb_s.valid) begin
            busy_s  = 1'b0;
            state_s = RUN;
          end else begin
            state_s = REL;
          end
        end else begin
          state_s = REL;
        end
        if (nb_s.valid) begin
          if (cnt_r == gap_r) begin
            cnt_s = CNT_ZERO;
            k_s   = nb_s.idx;
          end else begin
            cnt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = CNT_ZERO;
        end
      end

      RUN: begin
        if (swreset_req && (chmask != {NCH{1'b0}})) begin
          mask_s  = chmask;
          hold_s  = hold_cycles;
          gap_s   = gap_cycles;
          ch_s    = ch_cur_s & ~chmask;
          busy_s  = 1'b1;
          cnt_s   = CNT_ZERO;
          state_s = HOLD;
        end else begin
          state_s = RUN;
        end
      end

      default: begin
        state_s = SYNC;
        busy_s  = 1'b1;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= SYNC;
      cnt_r   <= CNT_ZERO;
      hold_r  <= CNT_ZERO;
      gap_r   <= CNT_ZERO;
      k_r     <= 4'd0;
      mask_r  <= {NCH{1'b1}};
      busy_r  <= 1'b1;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      hold_r  <= hold_s;
      gap_r   <= gap_s;
      k_r     <= k_s;
      mask_r  <= mask_s;
      busy_r  <= busy_s;
      drop_r  <= drop_s;
    end
  end

  // Replicated per-channel reset outputs, each bit its own flop.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      resetn_r <= {(NCH*FANOUT){1'b0}};
    end else begin
      for (int k = 0; k < NCH; k++) begin
        resetn_r[k*FANOUT +: FANOUT] <= {FANOUT{ch_s[k]}};
      end
    end
  end

  assign resetn   = resetn_r;
  assign busy     = busy_r;
  assign req_drop = drop_r;

`ifdef RESET_SEQ_SWCNT_EN
  logic        sw_r;
  logic [15:0] swcnt_r;

  // Track whether the running sequence was software-initiated and count
  // completed software sequences, saturating at all ones.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sw_r    <= 1'b0;
      swcnt_r <= 16'h0000;
    end else begin
      if ((state_r == RUN) && (state_s == HOLD)) begin
        sw_r <= 1'b1;
      end else if ((state_r == REL) && (state_s == RUN)) begin
        sw_r <= 1'b0;
        if (sw_r && (swcnt_r != 16'hFFFF)) begin
          swcnt_r <= swcnt_r + 16'h0001;
        end else begin
          swcnt_r <= swcnt_r;
        end
      end else begin
        sw_r <= sw_r;
      end
    end
  end

  assign swreset_cnt = swcnt_r;
`else
  assign swreset_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// Directed self-checking bench for reset_seq (NCH=4, SRWIDTH=4, FANOUT=8).
// Cycle n means the interval after the n-th rising clock edge following the
// aresetn release; outputs are sampled at the falling edge.
module tb_reset_seq;

  localparam int NCH = 4;
  localparam int FANOUT = 8;
  localparam int SRWIDTH = 4;
  localparam int CNTWIDTH = 16;

  logic                  clk;
  logic                  aresetn;
  logic [CNTWIDTH-1:0]   hold_cycles;
  logic [CNTWIDTH-1:0]   gap_cycles;
  logic                  swreset_req;
  logic [NCH-1:0]        chmask;
  logic [NCH*FANOUT-1:0] resetn;
  logic                  busy;
  logic                  req_drop;
  logic [15:0]           swreset_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] sw_exp;

  reset_seq #(.NCH(NCH), .FANOUT(FANOUT), .SRWIDTH(SRWIDTH), .CNTWIDTH(CNTWIDTH)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .hold_cycles (hold_cycles),
    .gap_cycles  (gap_cycles),
    .swreset_req (swreset_req),
    .chmask      (chmask),
    .resetn      (resetn),
    .busy        (busy),
    .req_drop    (req_drop),
    .swreset_cnt (swreset_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NCH-1:0] chans();
    logic [NCH-1:0] c;
    for (int k = 0; k < NCH; k++) c[k] = resetn[k*FANOUT];
    return c;
  endfunction

  function automatic logic uniform();
    logic u;
    u = 1'b1;
    for (int k = 0; k < NCH; k++)
      if (!((&resetn[k*FANOUT +: FANOUT]) || !(|resetn[k*FANOUT +: FANOUT]))) u = 1'b0;
    return u;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
`ifdef RESET_SEQ_SWCNT_EN
    sw_exp = 16'd1;
`else
    sw_exp = 16'd0;
`endif
    aresetn = 1'b0; hold_cycles = 16'd10; gap_cycles = 16'd3;
    swreset_req = 1'b0; chmask = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_resetn", resetn, 32'h0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_drop", 32'(req_drop), 32'd0);
    chk("rst_swcnt", 32'(swreset_cnt), 32'd0);

    // Power-up: hold=10, gap=3.
    aresetn = 1'b1; cyc = 0;
    go(4);  chk("pu_sync_ch", 32'(chans()), 32'h0); chk("pu_sync_busy", 32'(busy), 32'd1);
    go(7);  hold_cycles = 16'd2;               // change during HOLD
    go(8);  swreset_req = 1'b1; chmask = 4'b0001;
    go(9);  swreset_req = 1'b0; chmask = 4'b0000;
    chk("hold_drop_pulse", 32'(req_drop), 32'd1);
    go(10); chk("hold_drop_end", 32'(req_drop), 32'd0);
    go(15); chk("pu_c15", 32'(chans()), 32'h0);
    go(16); chk("pu_ch0", 32'(chans()), 32'h1); chk("pu_busy16", 32'(busy), 32'd1);
    go(19); chk("pu_c19", 32'(chans()), 32'h1);
    go(20); chk("pu_ch1", 32'(chans()), 32'h3);
    go(24); chk("pu_ch2", 32'(chans()), 32'h7);
    go(27); chk("pu_c27", 32'(chans()), 32'h7); chk("pu_busy27", 32'(busy), 32'd1);
    go(28); chk("pu_ch3", 32'(chans()), 32'hF); chk("pu_busy28", 32'(busy), 32'd0);
    chk("pu_uniform", 32'(uniform()), 32'd1); chk("pu_swcnt", 32'(swreset_cnt), 32'd0);

    // chmask==0 in RUN is ignored without a pulse.
    go(30); swreset_req = 1'b1; chmask = 4'b0000;
    go(31); swreset_req = 1'b0;
    chk("m0_drop", 32'(req_drop), 32'd0); chk("m0_ch", 32'(chans()), 32'hF);
    chk("m0_busy", 32'(busy), 32'd0);

    // Software re-run on channels 1 and 3, hold now 2, gap 3, t=32.
    go(32); swreset_req = 1'b1; chmask = 4'b1010;
    go(33); swreset_req = 1'b0; chmask = 4'b0000;
    chk("sw_drop_ch", 32'(chans()), 32'h5); chk("sw_busy33", 32'(busy), 32'd1);
    chk("sw_nodrop", 32'(req_drop), 32'd0);
    go(35); chk("sw_c35", 32'(chans()), 32'h5);
    go(36); chk("sw_ch1", 32'(chans()), 32'h7);
    go(39); chk("sw_c39", 32'(chans()), 32'h7); chk("sw_busy39", 32'(busy), 32'd1);
    go(40); chk("sw_ch3", 32'(chans()), 32'hF); chk("sw_busy40", 32'(busy), 32'd0);
    chk("sw_swcnt", 32'(swreset_cnt), 32'(sw_exp)); chk("sw_uniform", 32'(uniform()), 32'd1);

    // Full software re-run, then abort with aresetn during channel 2 gap.
    go(41); hold_cycles = 16'd1; gap_cycles = 16'd3;
    go(42); swreset_req = 1'b1; chmask = 4'b1111;
    go(43); swreset_req = 1'b0; chmask = 4'b0000;
    chk("ab_c43", 32'(chans()), 32'h0);
    go(45); chk("ab_c45", 32'(chans()), 32'h1);
    go(53); chk("ab_c53", 32'(chans()), 32'h7);
    go(54); aresetn = 1'b0; #1;
    chk("ab_resetn", resetn, 32'h0); chk("ab_busy", 32'(busy), 32'd1);
    chk("ab_swcnt", 32'(swreset_cnt), 32'd0); chk("ab_drop", 32'(req_drop), 32'd0);

    // Restart with hold=0, gap=0: acts as hold=1, consecutive releases.
    @(negedge clk); hold_cycles = 16'd0; gap_cycles = 16'd0;
    @(negedge clk); aresetn = 1'b1; cyc = 0;
    go(6);  chk("z_c6", 32'(chans()), 32'h0);
    go(7);  chk("z_c7", 32'(chans()), 32'h1);
    go(8);  chk("z_c8", 32'(chans()), 32'h3);
    go(9);  chk("z_c9", 32'(chans()), 32'h7); chk("z_busy9", 32'(busy), 32'd1);
    go(10); chk("z_c10", 32'(chans()), 32'hF); chk("z_busy10", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
